// File: rtl/uz_error_handler_pkg.sv
// Shared constants and types for the UltraZohm error handler AXI4-Lite slave.
// Register offsets, CTRL bit positions, AXI response codes and a byte-lane helper.
package uz_error_handler_pkg;

   typedef logic [1:0] reg_idx_t;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_MASK   = 4'h4;
   localparam logic [3:0] ADDR_STATUS = 4'h8;
   localparam logic [3:0] ADDR_COUNT  = 4'hC;

   localparam reg_idx_t IDX_CTRL   = ADDR_CTRL[3:2];
   localparam reg_idx_t IDX_MASK   = ADDR_MASK[3:2];
   localparam reg_idx_t IDX_STATUS = ADDR_STATUS[3:2];
   localparam reg_idx_t IDX_COUNT  = ADDR_COUNT[3:2];

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_SHDN_EN = 1;
   localparam int unsigned CTRL_CNT_CLR = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/uz_error_handler_axi_slave_capture.sv
// Error capture: sticky STATUS, saturating COUNT of rising unmasked events,
// and the registered interrupt / shutdown request.
module uz_error_capture
   import uz_error_handler_pkg::*;
#(
   parameter int unsigned NUM_ERR = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               shdn_en,
   input  logic [NUM_ERR-1:0] mask,
   input  logic [NUM_ERR-1:0] err_in,
   input  logic [NUM_ERR-1:0] status_clr,
   input  logic               cnt_clr,
   output logic [NUM_ERR-1:0] status,
   output logic [31:0]        count,
   output logic               err_irq,
   output logic               err_shutdown
);

   logic [NUM_ERR-1:0] err_q, rise, set;
   logic [NUM_ERR-1:0] status_q, status_d;
   logic [31:0]        count_q, count_d;
   logic               irq_q, shdn_q;

   always_comb begin
      rise     = err_in & ~err_q & ~mask;
      set      = en ? (err_in & ~mask) : '0;
      // set wins over a W1C of the same bit
      status_d = (status_q & ~status_clr) | set;
      count_d  = count_q;
      if (cnt_clr) begin
         count_d = '0;
      end else if (en && (|rise) && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q    <= '0;
         status_q <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
         shdn_q   <= 1'b0;
      end else begin
         err_q    <= err_in;
         status_q <= status_d;
         count_q  <= count_d;
         irq_q    <= en & (|status_d);
         shdn_q   <= en & shdn_en & (|status_d);
      end
   end

   assign status       = status_q;
   assign count        = count_q;
   assign err_irq      = irq_q;
   assign err_shutdown = shdn_q;

endmodule

// File: rtl/uz_error_handler_axi_slave.sv
// AXI4-Lite slave for the UltraZohm error handler: channel handshakes,
// register decode (CTRL, MASK, STATUS, COUNT) and registered read mux.
module uz_error_handler_axi_slave
   import uz_error_handler_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned NUM_ERR            = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   input  logic [NUM_ERR-1:0]              err_in,
   output logic                            err_irq,
   output logic                            err_shutdown
);

   logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic        arready_q, arready_d, rvalid_q, rvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [31:0] rdata_q, rdata_d, rd_mux;
   logic        aw_full_q, aw_full_d, w_full_q, w_full_d;
   reg_idx_t    awidx_q, awidx_d, wr_idx;
   logic [31:0] wdata_q, wdata_d, wr_data, wmask;
   logic [3:0]  wstrb_q, wstrb_d, wr_strb;
   logic        en_q, en_d, shdn_en_q, shdn_en_d, cnt_clr;
   logic [NUM_ERR-1:0] mask_q, mask_d, status_clr, status;
   logic [31:0] count;
   logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, do_write;
   logic        unused_ok;

   assign aw_hs    = s_axi_awvalid & awready_q;
   assign w_hs     = s_axi_wvalid & wready_q;
   assign ar_hs    = s_axi_arvalid & arready_q;
   assign b_hs     = bvalid_q & s_axi_bready;
   assign r_hs     = rvalid_q & s_axi_rready;
   // the write commits on the edge where the later of AW/W is accepted
   assign do_write = (aw_full_q | aw_hs) & (w_full_q | w_hs);
   assign wr_idx   = aw_full_q ? awidx_q : s_axi_awaddr[3:2];
   assign wr_data  = w_full_q ? wdata_q : s_axi_wdata;
   assign wr_strb  = w_full_q ? wstrb_q : s_axi_wstrb;
   assign wmask    = strb_mask(wr_strb);

   always_comb begin
      aw_full_d  = aw_full_q;
      w_full_d   = w_full_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      en_d       = en_q;
      shdn_en_d  = shdn_en_q;
      mask_d     = mask_q;
      status_clr = '0;
      cnt_clr    = 1'b0;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         awidx_d   = s_axi_awaddr[3:2];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = s_axi_wdata;
         wstrb_d  = s_axi_wstrb;
      end
      if (do_write) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = (wr_idx == IDX_COUNT) ? RESP_SLVERR : RESP_OKAY;
         unique case (wr_idx)
            IDX_CTRL: begin
               if (wr_strb[0]) begin
                  en_d      = wr_data[CTRL_EN];
                  shdn_en_d = wr_data[CTRL_SHDN_EN];
                  cnt_clr   = wr_data[CTRL_CNT_CLR];
               end
            end
            IDX_MASK: begin
               for (int i = 0; i < NUM_ERR; i++) begin
                  mask_d[i] = wmask[i] ? wr_data[i] : mask_q[i];
               end
            end
            IDX_STATUS: begin
               for (int i = 0; i < NUM_ERR; i++) begin
                  status_clr[i] = wmask[i] & wr_data[i];
               end
            end
            IDX_COUNT: ;
         endcase
      end else if (b_hs) begin
         bvalid_d = 1'b0;
      end
      awready_d = ~aw_full_d & ~bvalid_d;
      wready_d  = ~w_full_d & ~bvalid_d;
   end

   always_comb begin
      rd_mux = '0;
      unique case (s_axi_araddr[3:2])
         IDX_CTRL:   rd_mux[1:0] = {shdn_en_q, en_q};
         IDX_MASK:   rd_mux[NUM_ERR-1:0] = mask_q;
         IDX_STATUS: rd_mux[NUM_ERR-1:0] = status;
         IDX_COUNT:  rd_mux = count;
      endcase
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (r_hs) begin
         rvalid_d = 1'b0;
      end
      arready_d = ~rvalid_d;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         awidx_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         en_q      <= 1'b0;
         shdn_en_q <= 1'b0;
         mask_q    <= '0;
      end else begin
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         awidx_q   <= awidx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         en_q      <= en_d;
         shdn_en_q <= shdn_en_d;
         mask_q    <= mask_d;
      end
   end

   uz_error_capture #(
      .NUM_ERR(NUM_ERR)
   ) u_capture (
      .clk         (ACLK),
      .rst_n       (ARESETN),
      .en          (en_q),
      .shdn_en     (shdn_en_q),
      .mask        (mask_q),
      .err_in      (err_in),
      .status_clr  (status_clr),
      .cnt_clr     (cnt_clr),
      .status      (status),
      .count       (count),
      .err_irq     (err_irq),
      .err_shutdown(err_shutdown)
   );

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = RESP_OKAY;

   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr, wr_data, wmask};

endmodule
